// File: rtl/switch_pkg.sv
// Shared packet-layout constants and scheduler state type for the switch egress path.
package switch_pkg;

  localparam int DA_IDX    = 0;
  localparam int SA_IDX    = 1;
  localparam int LEN_IDX   = 2;
  localparam int HDR_BYTES = 3;

  typedef enum logic {
    IDLE,
    XFER
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping to 0.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PTR_W-1:0]     gnt_idx
);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_PORTS);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_port_sched.sv
// Packet-level round-robin scheduler: grants one fifo_mem queue per packet and streams it to egress.
module out_port_sched
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int W_WIDTH   = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           sched_en,
  input  logic [NUM_PORTS-1:0]           fifo_empty,
  input  logic [NUM_PORTS*W_WIDTH-1:0]   fifo_q,
  output logic [NUM_PORTS-1:0]           fifo_rd_en,
  input  logic                           out_ready,
  output logic                           out_valid,
  output logic [W_WIDTH-1:0]             out_data,
  output logic                           out_sop,
  output logic                           out_eop,
  output logic [NUM_PORTS-1:0]           grant,
  output logic                           busy
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CW    = W_WIDTH + 2;

  sched_state_t         state, state_nxt;
  logic [PTR_W-1:0]     gnt_idx, gnt_idx_nxt;
  logic [PTR_W-1:0]     rr_ptr, rr_ptr_nxt;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic [CW-1:0]        byte_cnt, byte_cnt_nxt;
  logic [W_WIDTH-1:0]   len_reg, len_reg_nxt;

  logic [NUM_PORTS-1:0] arb_gnt;
  logic [PTR_W-1:0]     arb_idx;
  logic [W_WIDTH-1:0]   cur_q;
  logic                 cur_empty;
  logic [W_WIDTH-1:0]   len_eff;
  logic                 handshake;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_arb (
    .req     (~fifo_empty),
    .ptr     (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign cur_q     = fifo_q[gnt_idx*W_WIDTH +: W_WIDTH];
  assign cur_empty = fifo_empty[gnt_idx];
  // LEN is live on the bus during its own beat, so a LEN=0 packet can end on that byte.
  assign len_eff   = (byte_cnt == CW'(LEN_IDX)) ? cur_q : len_reg;

  always_comb begin
    out_valid    = 1'b0;
    out_data     = '0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    fifo_rd_en   = '0;
    busy         = 1'b0;
    handshake    = 1'b0;
    state_nxt    = state;
    grant_nxt    = grant;
    gnt_idx_nxt  = gnt_idx;
    rr_ptr_nxt   = rr_ptr;
    byte_cnt_nxt = byte_cnt;
    len_reg_nxt  = len_reg;

    unique case (state)
      IDLE: begin
        if (sched_en && |(~fifo_empty)) begin
          grant_nxt    = arb_gnt;
          gnt_idx_nxt  = arb_idx;
          byte_cnt_nxt = '0;
          state_nxt    = XFER;
        end
      end
      XFER: begin
        busy       = 1'b1;
        out_valid  = !cur_empty;
        out_data   = cur_q;
        handshake  = out_valid && out_ready;
        fifo_rd_en = handshake ? grant : '0;
        out_sop    = out_valid && (byte_cnt == CW'(DA_IDX));
        out_eop    = out_valid && (byte_cnt >= CW'(LEN_IDX)) &&
                     (byte_cnt == CW'(LEN_IDX) + CW'(len_eff));
        if (handshake) begin
          byte_cnt_nxt = byte_cnt + CW'(1);
          if (byte_cnt == CW'(LEN_IDX))
            len_reg_nxt = cur_q;
          if (out_eop) begin
            state_nxt  = IDLE;
            grant_nxt  = '0;
            rr_ptr_nxt = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      gnt_idx  <= '0;
      rr_ptr   <= '0;
      byte_cnt <= '0;
      len_reg  <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      gnt_idx  <= gnt_idx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      byte_cnt <= byte_cnt_nxt;
      len_reg  <= len_reg_nxt;
    end
  end

endmodule

// File: tb/tb_out_port_sched.sv
// Directed bench for out_port_sched: behavioural show-ahead queues feed the DUT, outputs checked per cycle.
module tb_out_port_sched;

  localparam int NP = 4;
  localparam int W  = 8;

  logic            clk;
  logic            rst_n;
  logic            sched_en;
  logic [NP-1:0]   fifo_empty;
  logic [NP*W-1:0] fifo_q;
  logic [NP-1:0]   fifo_rd_en;
  logic            out_ready;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_sop;
  logic            out_eop;
  logic [NP-1:0]   grant;
  logic            busy;

  logic [7:0] fq [NP][$];
  int n_tests;
  int n_fail;

  out_port_sched #(
    .NUM_PORTS (NP),
    .W_WIDTH   (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sched_en   (sched_en),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rd_en (fifo_rd_en),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sop    (out_sop),
    .out_eop    (out_eop),
    .grant      (grant),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic sync_fifos();
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i]     = (fq[i].size() == 0);
      fifo_q[i*W +: W]  = (fq[i].size() == 0) ? 8'h00 : fq[i][0];
    end
  endtask

  task automatic push(input int p, input logic [7:0] b);
    fq[p].push_back(b);
    sync_fifos();
  endtask

  task automatic push_pkt(input int p, input logic [7:0] da, input logic [7:0] sa,
                          input logic [7:0] len, input logic [7:0] base);
    push(p, da);
    push(p, sa);
    push(p, len);
    for (int k = 0; k < int'(len); k++) push(p, base + 8'(k));
  endtask

  // Pops follow the strobe seen just before the edge, as a real fifo_mem would.
  task automatic step();
    logic [NP-1:0] pm;
    pm = fifo_rd_en;
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++)
      if (pm[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    sync_fifos();
  endtask

  task automatic exp_idle(input string tag);
    out_ready = 1'b1;
    #1;
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".grant"}, 32'(grant), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".rd_en"}, 32'(fifo_rd_en), 32'd0);
    step();
  endtask

  task automatic exp_cyc(input string tag, input logic rdy, input logic v, input logic [7:0] d,
                         input logic sop, input logic eop, input logic [NP-1:0] g);
    out_ready = rdy;
    #1;
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) check({tag, ".data"}, 32'(out_data), 32'(d));
    check({tag, ".sop"}, 32'(out_sop), 32'(sop));
    check({tag, ".eop"}, 32'(out_eop), 32'(eop));
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".busy"}, 32'(busy), 32'd1);
    check({tag, ".rd_en"}, 32'(fifo_rd_en), (v && rdy) ? 32'(g) : 32'd0);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".valid"}, 32'(out_valid), 32'd0);
    check({tag, ".data"}, 32'(out_data), 32'd0);
    check({tag, ".sop"}, 32'(out_sop), 32'd0);
    check({tag, ".eop"}, 32'(out_eop), 32'd0);
    check({tag, ".grant"}, 32'(grant), 32'd0);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".rd_en"}, 32'(fifo_rd_en), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NP; i++) fq[i].delete();
    sync_fifos();
    #1;
    check_all_zero("reset");
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    sched_en  = 1'b0;
    out_ready = 1'b0;
    sync_fifos();
    #2;
    do_reset();

    // 1: single packet on port 1
    sched_en = 1'b1;
    push_pkt(1, 8'h05, 8'h01, 8'h02, 8'hAA);
    fq[1][4] = 8'hBB;
    sync_fifos();
    exp_idle("t1.arb");
    exp_cyc("t1.b0", 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 4'b0010);
    exp_cyc("t1.b1", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t1.b2", 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t1.b3", 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t1.b4", 1'b1, 1'b1, 8'hBB, 1'b0, 1'b1, 4'b0010);
    exp_idle("t1.end");

    // 2: ports 0,2,3 served in rr order after reset
    do_reset();
    push_pkt(0, 8'h10, 8'h00, 8'h01, 8'hC0);
    push_pkt(2, 8'h12, 8'h02, 8'h01, 8'hC2);
    push_pkt(3, 8'h13, 8'h03, 8'h01, 8'hC3);
    exp_idle("t2.arb0");
    exp_cyc("t2.p0b0", 1'b1, 1'b1, 8'h10, 1'b1, 1'b0, 4'b0001);
    exp_cyc("t2.p0b1", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0001);
    exp_cyc("t2.p0b2", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b0001);
    exp_cyc("t2.p0b3", 1'b1, 1'b1, 8'hC0, 1'b0, 1'b1, 4'b0001);
    exp_idle("t2.gap0");
    exp_cyc("t2.p2b0", 1'b1, 1'b1, 8'h12, 1'b1, 1'b0, 4'b0100);
    exp_cyc("t2.p2b1", 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 4'b0100);
    exp_cyc("t2.p2b2", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b0100);
    exp_cyc("t2.p2b3", 1'b1, 1'b1, 8'hC2, 1'b0, 1'b1, 4'b0100);
    exp_idle("t2.gap2");
    exp_cyc("t2.p3b0", 1'b1, 1'b1, 8'h13, 1'b1, 1'b0, 4'b1000);
    exp_cyc("t2.p3b1", 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 4'b1000);
    exp_cyc("t2.p3b2", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b1000);
    exp_cyc("t2.p3b3", 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, 4'b1000);

    // 3: LEN=0 packet on port 3, followed by a normal one
    push_pkt(3, 8'h33, 8'h03, 8'h00, 8'h00);
    push_pkt(3, 8'h34, 8'h03, 8'h01, 8'hD0);
    exp_idle("t3.arb");
    exp_cyc("t3.b0", 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 4'b1000);
    exp_cyc("t3.b1", 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 4'b1000);
    exp_cyc("t3.b2", 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 4'b1000);
    exp_idle("t3.gap");
    exp_cyc("t3.n0", 1'b1, 1'b1, 8'h34, 1'b1, 1'b0, 4'b1000);
    exp_cyc("t3.n1", 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 4'b1000);
    exp_cyc("t3.n2", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b1000);
    exp_cyc("t3.n3", 1'b1, 1'b1, 8'hD0, 1'b0, 1'b1, 4'b1000);

    // 4: backpressure mid-packet on port 1
    push_pkt(1, 8'h41, 8'h01, 8'h02, 8'hE1);
    exp_idle("t4.arb");
    exp_cyc("t4.b0",  1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 4'b0010);
    exp_cyc("t4.s0",  1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t4.s1",  1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t4.b1",  1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t4.b2",  1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t4.b3",  1'b1, 1'b1, 8'hE1, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t4.b4",  1'b1, 1'b1, 8'hE2, 1'b0, 1'b1, 4'b0010);

    // 5: underrun on port 0 while port 1 waits
    push(0, 8'h50);
    push(0, 8'h00);
    push_pkt(1, 8'h51, 8'h01, 8'h01, 8'hF1);
    exp_idle("t5.arb");
    exp_cyc("t5.b0", 1'b1, 1'b1, 8'h50, 1'b1, 1'b0, 4'b0001);
    exp_cyc("t5.b1", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0001);
    exp_cyc("t5.u0", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0001);
    exp_cyc("t5.u1", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'b0001);
    push(0, 8'h01);
    push(0, 8'hF0);
    exp_cyc("t5.b2", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b0001);
    exp_cyc("t5.b3", 1'b1, 1'b1, 8'hF0, 1'b0, 1'b1, 4'b0001);
    exp_idle("t5.gap");
    exp_cyc("t5.p1b0", 1'b1, 1'b1, 8'h51, 1'b1, 1'b0, 4'b0010);
    exp_cyc("t5.p1b1", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t5.p1b2", 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 4'b0010);
    exp_cyc("t5.p1b3", 1'b1, 1'b1, 8'hF1, 1'b0, 1'b1, 4'b0010);

    // 6: reset at payload byte of LEN=8 packet on port 2
    push_pkt(2, 8'h60, 8'h02, 8'h08, 8'h80);
    push_pkt(0, 8'h70, 8'h00, 8'h00, 8'h00);
    exp_idle("t6.arb");
    exp_cyc("t6.b0", 1'b1, 1'b1, 8'h60, 1'b1, 1'b0, 4'b0100);
    exp_cyc("t6.b1", 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 4'b0100);
    exp_cyc("t6.b2", 1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 4'b0100);
    out_ready = 1'b1;
    #1;
    check("t6.b3.data", 32'(out_data), 32'h80);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6.rst");
    step();
    rst_n = 1'b1;
    exp_idle("t6.arb2");
    sched_en = 1'b0;
    exp_cyc("t6.p0b0", 1'b1, 1'b1, 8'h70, 1'b1, 1'b0, 4'b0001);
    exp_cyc("t6.p0b1", 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'b0001);
    exp_cyc("t6.p0b2", 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 4'b0001);
    exp_idle("t6.hold0");
    exp_idle("t6.hold1");
    check("t6.residue", 32'(fq[2].size()), 32'd8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
